// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide
// over magnitudes, one bit per cycle, with start/busy/done handshake.
module muldiv_unit #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [REG_WIDTH-1:0] in1,
  input  logic [REG_WIDTH-1:0] in2,
  output logic                 busy,
  output logic                 done,
  output logic [REG_WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(REG_WIDTH);
  localparam logic [REG_WIDTH-1:0] MIN_INT = {1'b1, {(REG_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_busy;
  logic                   r_done;
  logic [CNT_W-1:0]       r_count;
  logic [REG_WIDTH-1:0]   r_result;

  logic [2:0]             r_op;
  logic [REG_WIDTH-1:0]   r_hi;
  logic [REG_WIDTH-1:0]   r_lo;
  logic [REG_WIDTH-1:0]   r_b;
  logic                   r_neg_q;
  logic                   r_neg_r;

  logic                   w_accept;
  logic                   w_last;
  logic                   w_is_div;
  logic                   w_a_signed;
  logic                   w_b_signed;
  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [REG_WIDTH-1:0]   w_mag_a;
  logic [REG_WIDTH-1:0]   w_mag_b;
  logic                   w_div_zero;
  logic                   w_ovf;
  logic                   w_fast;
  logic [REG_WIDTH-1:0]   w_fast_res;

  logic [REG_WIDTH:0]     w_mul_sum;
  logic [REG_WIDTH:0]     w_div_sh;
  logic [REG_WIDTH:0]     w_div_diff;
  logic                   w_div_ge;
  logic [REG_WIDTH-1:0]   w_hi_nxt;
  logic [REG_WIDTH-1:0]   w_lo_nxt;
  logic [REG_WIDTH-1:0]   w_core_res;

  function automatic logic [REG_WIDTH-1:0] fix_sign(input logic [REG_WIDTH-1:0] v,
                                                    input logic neg);
    return neg ? (~v + {{(REG_WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*REG_WIDTH-1:0] fix_sign_wide(input logic [2*REG_WIDTH-1:0] v,
                                                           input logic neg);
    return neg ? (~v + {{(2*REG_WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

  // Acceptance: operand decode, magnitudes and fast-path detection
  assign w_accept   = start && (r_state != S_CALC);
  assign w_last     = (r_state == S_CALC) && (r_count == CNT_W'(REG_WIDTH-1));
  assign w_is_div   = funct3[2];
  assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_a_neg    = w_a_signed && in1[REG_WIDTH-1];
  assign w_b_neg    = w_b_signed && in2[REG_WIDTH-1];
  assign w_mag_a    = fix_sign(in1, w_a_neg);
  assign w_mag_b    = fix_sign(in2, w_b_neg);
  assign w_div_zero = w_is_div && (in2 == '0);
  assign w_ovf      = w_is_div && !funct3[0] && (in1 == MIN_INT) && (in2 == '1);
  assign w_fast     = w_div_zero || w_ovf;

  always_comb begin
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = funct3[1] ? in1 : '1;
    else if (w_ovf)
      w_fast_res = funct3[1] ? '0 : in1;
  end

  // Iteration: {hi,lo} is the product register for multiply, {remainder,quotient} for divide
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(REG_WIDTH+1){1'b0}});
  assign w_div_sh   = {r_hi, r_lo[REG_WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_b};
  assign w_div_ge   = !w_div_diff[REG_WIDTH];

  always_comb begin
    if (r_op[2]) begin
      w_hi_nxt = w_div_ge ? w_div_diff[REG_WIDTH-1:0] : w_div_sh[REG_WIDTH-1:0];
      w_lo_nxt = {r_lo[REG_WIDTH-2:0], w_div_ge};
    end else begin
      w_hi_nxt = w_mul_sum[REG_WIDTH:1];
      w_lo_nxt = {w_mul_sum[0], r_lo[REG_WIDTH-1:1]};
    end
  end

  always_comb begin
    logic [2*REG_WIDTH-1:0] w_prod;
    w_prod     = fix_sign_wide({w_hi_nxt, w_lo_nxt}, r_neg_q);
    w_core_res = '0;
    case (r_op)
      3'b000:         w_core_res = w_prod[REG_WIDTH-1:0];
      3'b100, 3'b101: w_core_res = fix_sign(w_lo_nxt, r_neg_q);
      3'b110, 3'b111: w_core_res = fix_sign(w_hi_nxt, r_neg_r);
      default:        w_core_res = w_prod[2*REG_WIDTH-1:REG_WIDTH];
    endcase
  end

  // Control FSM
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_fast ? S_DONE : S_CALC;
      S_CALC:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = start ? (w_fast ? S_DONE : S_CALC) : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= '0;
      r_result <= '0;
    end else begin
      r_busy <= (w_state_nxt == S_CALC);
      r_done <= (w_state_nxt == S_DONE);
      if (w_accept)
        r_count <= '0;
      else if (r_state == S_CALC)
        r_count <= r_count + CNT_W'(1);
      if (w_accept && w_fast)
        r_result <= w_fast_res;
      else if (w_last)
        r_result <= w_core_res;
    end
  end

  // Datapath registers: loaded on acceptance, stepped while calculating
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op    <= funct3;
      r_hi    <= '0;
      r_lo    <= w_is_div ? w_mag_a : w_mag_b;
      r_b     <= w_is_div ? w_mag_b : w_mag_a;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
    end else if (r_state == S_CALC) begin
      r_hi <= w_hi_nxt;
      r_lo <= w_lo_nxt;
    end
  end

endmodule
